// File: rtl/dff_share_pkg.sv
// Shared definitions for the dff_share_arbiter slice.
//   state_t   : arbiter FSM encoding (IDLE / GRANT / ACK)
//   MAX_NREQ  : largest supported requester count
//   ptr_width : width of the round-robin pointer for a given requester count
//   onehot    : index -> one-hot vector (MAX_NREQ bits, callers truncate)
package dff_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int MAX_NREQ = 8;

  // clog2 with a floor of 1 so a pointer always has at least one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
    return MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   ptr    : index that gets highest priority this round
//   valid  : at least one request is present
//   winner : first requesting index at or after ptr, wrapping mod NREQ
// The request vector is rotated so that ptr lands on bit 0, the lowest set
// bit is found, and the rotation is added back to recover the real index.
module rr_pick
  import dff_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] winner
);

  localparam logic [PTR_W:0] NREQ_EXT = NREQ[PTR_W:0];

  // (a + b) mod NREQ for a, b < NREQ; explicit wrap so non-power-of-2
  // requester counts stay in range.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NREQ_EXT) s = s - NREQ_EXT;
    return s[PTR_W-1:0];
  endfunction

  logic [NREQ-1:0]  rot;
  logic [PTR_W-1:0] pick;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rot[gi] = req[wrap_add(ptr, PTR_W'(gi))];
    end
  endgenerate

  // Lowest set bit of the rotated vector; scanning downward lets the
  // lowest index overwrite the others.
  always_comb begin
    pick = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) pick = PTR_W'(j);
    end
  end

  assign valid  = |req;
  assign winner = wrap_add(ptr, pick);

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter owning one shared WIDTH-bit register.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   req   : per-requester write request (level)
//   wdata : packed write data, requester i owns [i*WIDTH +: WIDTH]
//   gnt   : registered one-hot grant, high for the GRANT cycle
//   ack   : registered one-hot write-done pulse, one cycle
//   q     : shared register contents
//   busy  : high whenever the FSM is not IDLE
// One write takes IDLE -> GRANT -> ACK; the winner is latched on entry to
// GRANT and its data is captured on the GRANT -> ACK edge only if it is still
// requesting, otherwise the grant is dropped with no write.
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PTR_W = ptr_width(NREQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] w_reg, w_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [NREQ-1:0]  ack_reg, ack_next;
  logic [WIDTH-1:0] q_reg, q_next;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;

  // Unpacked view of the write data, one word per requester.
  logic [WIDTH-1:0] wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_wdata
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      w_reg     <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      w_reg     <= w_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      q_reg     <= q_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = pick_valid ? GRANT : IDLE;
      GRANT:   state_next = req[w_reg] ? ACK : IDLE;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    w_next   = w_reg;
    ptr_next = ptr_reg;
    gnt_next = '0;
    ack_next = '0;
    q_next   = q_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          w_next   = pick_idx;
          gnt_next = NREQ'(onehot(3'(pick_idx)));
        end
      end
      GRANT: begin
        // A dropped request abandons the slot: no write, pointer untouched.
        if (req[w_reg]) begin
          q_next   = wdata_arr[w_reg];
          ack_next = NREQ'(onehot(3'(w_reg)));
          ptr_next = (w_reg == LAST_IDX) ? '0 : w_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt  = gnt_reg;
  assign ack  = ack_reg;
  assign q    = q_reg;
  assign busy = (state_reg != IDLE);

endmodule
